wshb_pixel_sink: RTL and testbench

//  Wishbone B4 responder for the pixel stream bus driven by hw_support. It replaces the tie-off (ack=1, dat_sm=0).

---
 rtl/wshb_pixel_sink_if.sv | 25 ++
 rtl/wshb_pixel_sink.sv | 163 ++++++++++++++++
 tb/tb_wshb_pixel_sink.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_pixel_sink_if.sv
// Wishbone B4 classic bus bundle shared by the pixel stream side and the SDRAM side.
interface wshb_pixel_sink_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_pixel_sink.sv
// Accepts pixel writes from the stream bus, buffers them in a FIFO and writes them
// into the SDRAM framebuffer in raster order through a Wishbone master port.
module wshb_pixel_sink #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter logic [31:0] BASE_ADR   = 32'h0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  wshb_pixel_sink_if.slave              s,
  wshb_pixel_sink_if.master             m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          err_sticky
);

  localparam int unsigned NPix   = HDISP * VDISP;
  localparam int unsigned IdxW   = (NPix > 1) ? $clog2(NPix) : 1;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BurstW = $clog2(MAX_BURST) + 1;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        sof;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StWrite, StGap} state_e;

  state_e            state_q, state_d;
  entry_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [IdxW-1:0]   pix_idx_q, pix_idx_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              err_q, err_d;

  logic   full, empty, push, pop, more;
  entry_t head;
  logic [IdxW-1:0] idx, idx_next;
  logic   last;
  logic   unused_ok;

  assign unused_ok = ^{s.cti, s.bte, m.dat_sm};

  // ---------------- slave side ----------------
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = s.cyc & s.stb & s.we & ~full;

  // Responses are forced low while reset is held so all outputs read 0.
  assign s.ack    = sys_rst_n & push;
  assign s.err    = sys_rst_n & s.cyc & s.stb & ~s.we;
  assign s.rty    = 1'b0;
  assign s.dat_sm = '0;

  // ---------------- FIFO ----------------
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{dat: s.dat_ms, sel: s.sel, sof: (s.adr == '0)};
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  assign fifo_level = count_q;

  // ---------------- master FSM ----------------
  assign idx      = head.sof ? '0 : pix_idx_q;
  assign last     = (idx == IdxW'(NPix - 1));
  assign idx_next = last ? '0 : idx + IdxW'(1);
  // Head has already been counted; another word remains if more than one is queued or one arrives.
  assign more     = push || (count_q > CntW'(1));

  always_comb begin
    state_d    = state_q;
    pix_idx_d  = pix_idx_q;
    burst_d    = burst_q;
    err_d      = err_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    m.cyc      = 1'b0;
    m.stb      = 1'b0;
    m.we       = 1'b0;
    m.adr      = '0;
    m.dat_ms   = '0;
    m.sel      = '0;
    m.cti      = 3'b000;
    m.bte      = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        m.cyc    = 1'b1;
        m.stb    = 1'b1;
        m.we     = 1'b1;
        m.sel    = head.sel;
        m.dat_ms = head.dat;
        m.adr    = BASE_ADR + (32'(idx) << 2);
        if (m.ack) begin
          pop        = 1'b1;
          pix_idx_d  = idx_next;
          burst_d    = burst_q + BurstW'(1);
          frame_done = last;
          if (!(more && (burst_q < BurstW'(MAX_BURST - 1)))) begin
            state_d = StGap;
          end
        end else if (m.err) begin
          pop       = 1'b1;
          pix_idx_d = idx_next;
          err_d     = 1'b1;
          state_d   = StGap;
        end else if (m.rty) begin
          state_d = StGap;
        end
      end
      StGap: begin
        burst_d = '0;
        state_d = empty ? StIdle : StWrite;
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_sticky = err_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pix_idx_q <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pix_idx_q <= pix_idx_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

endmodule

// File: tb/tb_wshb_pixel_sink.sv
// Randomised scoreboard bench for wshb_pixel_sink with a transaction-level framebuffer model.
module tb_wshb_pixel_sink;
  localparam int unsigned HDISP      = 4;
  localparam int unsigned VDISP      = 2;
  localparam int unsigned NPIX       = HDISP * VDISP;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MAX_BURST  = 2;
  localparam logic [31:0] BASE_ADR   = 32'h100;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  wshb_pixel_sink_if s_bus ();
  wshb_pixel_sink_if m_bus ();
  logic [2:0] fifo_level;
  logic       frame_done;
  logic       err_sticky;

  wshb_pixel_sink #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .BASE_ADR  (BASE_ADR),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .s         (s_bus),
    .m         (m_bus),
    .fifo_level(fifo_level),
    .frame_done(frame_done),
    .err_sticky(err_sticky)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  int          script_q[$];   // 1 ack, 2 err, 3 rty
  int          model_cnt;
  int unsigned model_idx;
  bit          model_err;
  bit          expect_gap;
  int          acks_in_run;
  int          resp_mode;     // 0 always ack, 1 random, 2 stall
  int          vectors;
  int          miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- scoreboard / monitor ----------------
  bit          exp_push, exp_rd, do_pop, sof;
  int unsigned cur_idx;
  wr_t         ent;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      check("rst_m_cyc", 32'(m_bus.cyc), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_s_ack", 32'(s_bus.ack), 32'd0);
      check("rst_err_sticky", 32'(err_sticky), 32'd0);
      exp_q.delete();
      model_cnt   = 0;
      model_idx   = 0;
      model_err   = 1'b0;
      expect_gap  = 1'b0;
      acks_in_run = 0;
    end else begin
      exp_push = s_bus.cyc && s_bus.stb && s_bus.we && (model_cnt < FIFO_DEPTH);
      exp_rd   = s_bus.cyc && s_bus.stb && !s_bus.we;
      do_pop   = 1'b0;
      check("fifo_level", 32'(fifo_level), 32'(model_cnt));
      check("err_sticky", 32'(err_sticky), 32'(model_err));
      if (s_bus.cyc && s_bus.stb) begin
        check("s_ack", 32'(s_bus.ack), 32'(exp_push));
        check("s_err", 32'(s_bus.err), 32'(exp_rd));
      end
      if (expect_gap) check("gap_m_cyc", 32'(m_bus.cyc), 32'd0);
      expect_gap = 1'b0;

      if (m_bus.cyc && m_bus.stb) begin
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_master_write");
        end else begin
          check("m_adr", m_bus.adr, exp_q[0].adr);
          check("m_dat", m_bus.dat_ms, exp_q[0].dat);
          check("m_sel", 32'(m_bus.sel), 32'(exp_q[0].sel));
          check("m_we", 32'(m_bus.we), 32'd1);
          if (m_bus.ack) begin
            check("frame_done", 32'(frame_done), 32'(exp_q[0].last));
            do_pop = 1'b1;
            acks_in_run++;
            expect_gap = (acks_in_run == MAX_BURST) || (model_cnt == 1 && !exp_push);
          end else begin
            check("frame_done_idle", 32'(frame_done), 32'd0);
            if (m_bus.err) begin
              do_pop     = 1'b1;
              model_err  = 1'b1;
              expect_gap = 1'b1;
            end else if (m_bus.rty) begin
              expect_gap = 1'b1;
            end
          end
        end
      end else begin
        acks_in_run = 0;
      end

      if (do_pop) void'(exp_q.pop_front());
      if (exp_push) begin
        sof     = (s_bus.adr == 32'd0);
        cur_idx = sof ? 0 : model_idx;
        ent.adr  = BASE_ADR + 32'(cur_idx * 4);
        ent.dat  = s_bus.dat_ms;
        ent.sel  = s_bus.sel;
        ent.last = (cur_idx == NPIX - 1);
        exp_q.push_back(ent);
        model_idx = (cur_idx + 1) % NPIX;
      end
      model_cnt = model_cnt + int'(exp_push) - int'(do_pop);
    end
  end

  // ---------------- SDRAM responder ----------------
  int r;
  always @(posedge sys_clk) begin
    #1;
    m_bus.ack = 1'b0;
    m_bus.err = 1'b0;
    m_bus.rty = 1'b0;
    if (sys_rst_n && m_bus.cyc && m_bus.stb) begin
      if (script_q.size() != 0) begin
        r = script_q.pop_front();
      end else if (resp_mode == 0) begin
        r = 1;
      end else if (resp_mode == 1) begin
        r = $urandom_range(0, 9);
        r = (r < 6) ? 1 : (r == 6) ? 2 : (r == 7) ? 3 : 0;
      end else begin
        r = 0;
      end
      m_bus.ack = (r == 1);
      m_bus.err = (r == 2);
      m_bus.rty = (r == 3);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    s_bus.we  = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    s_bus.cyc    = 1'b1;
    s_bus.stb    = 1'b1;
    s_bus.we     = we;
    s_bus.adr    = adr;
    s_bus.dat_ms = dat;
    s_bus.sel    = sel;
  endtask

  // One beat, accepted or not.
  task automatic beat(input logic [31:0] adr, input logic [31:0] dat);
    drive(1'b1, adr, dat, 4'hf);
    @(posedge sys_clk);
    #1;
  endtask

  // Holds the write until the sink accepts it.
  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic got;
    drive(1'b1, adr, dat, sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      got = s_bus.ack;
      @(posedge sys_clk);
      #1;
      if (got) return;
    end
    flag_fail("write_accept_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (model_cnt == 0 && exp_q.size() == 0 && !m_bus.cyc) begin
        @(posedge sys_clk);
        #1;
        return;
      end
    end
    flag_fail("drain_timeout");
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resp_mode   = 0;
    idle();
    s_bus.adr    = '0;
    s_bus.dat_ms = '0;
    s_bus.sel    = '0;
    s_bus.cti    = '0;
    s_bus.bte    = '0;
    m_bus.dat_sm = '0;
    m_bus.ack    = 1'b0;
    m_bus.err    = 1'b0;
    m_bus.rty    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Four pixels of a fresh frame, always acked: two bursts of two.
    wr(32'd0,  32'hD000_0000, 4'hf);
    wr(32'd4,  32'hD000_0001, 4'h3);
    wr(32'd8,  32'hD000_0002, 4'hc);
    wr(32'd12, 32'hD000_0003, 4'h1);
    idle();
    drain();

    // Reset in the middle of a stalled write, then the index restarts at pixel 0.
    resp_mode = 2;
    wr(32'd16, 32'hAAAA_0004, 4'hf);
    idle();
    for (int i = 0; i < 20 && !m_bus.cyc; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check("pre_rst_m_cyc", 32'(m_bus.cyc), 32'd1);
    sys_rst_n = 1'b0;
    #1 check("async_rst_m_cyc", 32'(m_bus.cyc), 32'd0);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    resp_mode = 0;
    sys_rst_n = 1'b1;
    wr(32'd20, 32'hBBBB_0000, 4'hf);
    idle();
    drain();

    // Five back-to-back beats into a stalled sink: the fifth is refused.
    resp_mode = 2;
    beat(32'd0, 32'hC000_0000);
    for (int i = 1; i < 5; i++) beat(32'(i * 4), 32'hC000_0000 + 32'(i));
    idle();
    @(negedge sys_clk);
    check("full_level", 32'(fifo_level), 32'd4);
    @(posedge sys_clk);
    #1;
    resp_mode = 0;
    drain();

    // A whole frame plus one: frame_done on the last pixel, then wrap.
    for (int i = 0; i < 9; i++) wr(32'(i * 4 + (i == 0 ? 0 : 64)), 32'hF000_0000 + 32'(i), 4'hf);
    idle();
    drain();

    // Start-of-frame resync after three pixels.
    for (int i = 0; i < 3; i++) wr(32'(i * 4 + 4), 32'h5000_0000 + 32'(i), 4'hf);
    wr(32'd0, 32'h5000_00FF, 4'h7);
    idle();
    drain();

    // Retry then error on the second word.
    resp_mode = 2;
    wr(32'd0, 32'h6000_0000, 4'hf);
    wr(32'd4, 32'h6000_0001, 4'hf);
    wr(32'd8, 32'h6000_0002, 4'hf);
    idle();
    script_q = '{1, 3, 2, 1};
    resp_mode = 0;
    drain();
    @(negedge sys_clk);
    check("err_sticky_set", 32'(err_sticky), 32'd1);
    @(posedge sys_clk);
    #1;

    // Read cycle is rejected.
    drive(1'b0, 32'd8, 32'h0, 4'hf);
    @(negedge sys_clk);
    check("read_s_err", 32'(s_bus.err), 32'd1);
    check("read_s_ack", 32'(s_bus.ack), 32'd0);
    @(posedge sys_clk);
    #1;
    idle();

    // Random traffic with random SDRAM responses.
    resp_mode = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    idle();
        2:       drive(1'b0, 32'($urandom_range(1, 255)) * 4, $urandom, 4'hf);
        default: drive(1'b1, ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 255)) * 4,
                       $urandom, 4'($urandom));
      endcase
      @(posedge sys_clk);
      #1;
    end
    idle();
    resp_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
